// File: rtl/rt_ctrl_pkg.sv
// Shared types for the racetrack access controller: FSM state encoding and
// shift-direction constants.
package rt_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        ALIGN    = 4'd1,
        SHIFT_HI = 4'd2,
        SHIFT_LO = 4'd3,
        SETUP    = 4'd4,
        WR_PULSE = 4'd5,
        WR_LO    = 4'd6,
        RD_PULSE = 4'd7,
        RD_CAP   = 4'd8,
        RESP     = 4'd9
    } rt_state_e;

    // current_s encoding: forward moves offset+1, backward moves offset-1
    localparam logic RT_FWD = 1'b0;
    localparam logic RT_BWD = 1'b1;

endpackage

// File: rtl/rt_offset_tracker.sv
// Mirrors the domain position under the access port of a non-circular track
// and reports whether the target is aligned and which way to shift.
module rt_offset_tracker
    import rt_ctrl_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rstn,
    input  logic          shift_en,
    input  logic          shift_dir,
    input  logic [AW-1:0] target,
    output logic [AW-1:0] offset,
    output logic          at_target,
    output logic          dir
);

    localparam logic [AW-1:0] LAST_POS = AW'(DEPTH - 1);

    assign at_target = (offset == target);
    assign dir       = (target < offset) ? RT_BWD : RT_FWD;

    // Ends of the track clamp rather than wrap, matching the physical cells
    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            offset <= '0;
        end else if (shift_en) begin
            if (shift_dir == RT_BWD) begin
                if (offset != '0) offset <= offset - 1'b1;
            end else begin
                if (offset != LAST_POS) offset <= offset + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rt_access_ctrl.sv
// Racetrack bank sequencer: aligns the addressed domain under the access port
// with shift pulses, then issues one write or read pulse and a response.
// Optional shift statistics counter enabled by defining RT_SHIFT_STATS_EN.
module rt_access_ctrl
    import rt_ctrl_pkg::*;
#(
    parameter  int DEPTH  = 16,
    parameter  int DATA_W = 8,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [AW-1:0]     req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rt_current_m,
    output logic              rt_current_s,
    output logic              rt_write_enable,
    output logic [DATA_W-1:0] rt_write_input,
    output logic              rt_read_current,
`ifdef RT_SHIFT_STATS_EN
    input  logic              shift_cnt_clr,
    output logic [31:0]       shift_cnt,
`endif
    input  logic [DATA_W-1:0] rt_read_out
);

    localparam logic [AW:0] DEPTH_EXT = (AW + 1)'(DEPTH);

    rt_state_e         state, state_nx;
    logic              lat_we;
    logic [AW-1:0]     lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              accept;
    logic              addr_oor;
    logic [AW-1:0]     trk_offset;
    logic              trk_at_target;
    logic              trk_dir;

    assign accept   = req_valid && req_ready;
    assign addr_oor = ({1'b0, req_addr} >= DEPTH_EXT);

    rt_offset_tracker #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_off (
        .clk_i    (clk_i),
        .rstn     (rstn),
        .shift_en (state == SHIFT_HI),
        .shift_dir(rt_current_s),
        .target   (lat_addr),
        .offset   (trk_offset),
        .at_target(trk_at_target),
        .dir      (trk_dir)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (accept) state_nx = addr_oor ? RESP : ALIGN;
            ALIGN:    state_nx = trk_at_target ? SETUP : SHIFT_HI;
            SHIFT_HI: state_nx = SHIFT_LO;
            SHIFT_LO: state_nx = ALIGN;
            SETUP:    state_nx = lat_we ? WR_PULSE : RD_PULSE;
            WR_PULSE: state_nx = WR_LO;
            WR_LO:    state_nx = RESP;
            RD_PULSE: state_nx = RD_CAP;
            RD_CAP:   state_nx = RESP;
            RESP:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Request fields only matter after a handshake, so they carry no reset
    always_ff @(posedge clk_i) begin
        if (accept) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
        end
    end

    // Outputs are decoded from the next state so every cell-facing line is a flop
    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            state           <= IDLE;
            req_ready       <= 1'b1;
            rsp_valid       <= 1'b0;
            rsp_err         <= 1'b0;
            rsp_rdata       <= '0;
            rt_current_m    <= 1'b0;
            rt_current_s    <= RT_FWD;
            rt_write_enable <= 1'b0;
            rt_write_input  <= '0;
            rt_read_current <= 1'b0;
        end else begin
            state           <= state_nx;
            req_ready       <= (state_nx == IDLE);
            rsp_valid       <= (state_nx == RESP);
            rsp_err         <= (state == IDLE) && (state_nx == RESP);
            rsp_rdata       <= (state == RD_CAP) ? rt_read_out : '0;
            rt_current_m    <= (state_nx == SHIFT_HI);
            rt_write_enable <= (state_nx == WR_PULSE);
            rt_read_current <= (state_nx == RD_PULSE);
            if (state == ALIGN) begin
                rt_current_s <= trk_at_target ? RT_FWD : trk_dir;
                if (trk_at_target && lat_we) rt_write_input <= lat_wdata;
            end
        end
    end

`ifdef RT_SHIFT_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            shift_cnt <= '0;
        end else if (shift_cnt_clr) begin
            shift_cnt <= '0;
        end else if (state == SHIFT_HI) begin
            shift_cnt <= sat_inc(shift_cnt);
        end
    end
`endif

endmodule
